// File: rtl/atwo_pkg.sv
// atwo_pkg: shared aTwo bus widths, arbiter state encoding and arbitration defaults
package atwo_pkg;
  localparam int ATWO_ADDR_W = 8;
  localparam int ATWO_DATA_W = 8;
  localparam int ATWO_BURST_MAX = 4;
  localparam int ATWO_CORE_MIN = 2;
  typedef enum logic [1:0] {
    ST_CORE = 2'b00,
    ST_EXT  = 2'b01,
    ST_SLOT = 2'b10
  } arb_state_t;
endpackage

// File: rtl/atwo_mbus_arbiter.sv
// atwo_mbus_arbiter: shares the memory bus between the aTwo core and one external master
module atwo_mbus_arbiter
  import atwo_pkg::*;
#(
  parameter int ADDR_W = ATWO_ADDR_W,
  parameter int DATA_W = ATWO_DATA_W,
  parameter int BURST_MAX = ATWO_BURST_MAX,
  parameter int CORE_MIN = ATWO_CORE_MIN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdat,
  input  logic              core_r,
  input  logic              core_w,
  output logic [DATA_W-1:0] core_rdat,
  output logic              core_ce,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdat,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdat,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdat,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdat
);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int SW = $clog2(CORE_MIN + 1);
  arb_state_t r_state, w_next;
  logic [BW-1:0] r_beats;
  logic [SW-1:0] r_slot;
  logic w_ext, w_beat, w_last_beat, w_last_slot;
  assign w_ext = r_state == ST_EXT;
  assign w_beat = w_ext & ext_req;
  assign w_last_beat = r_beats == BW'(BURST_MAX - 1);
  assign w_last_slot = r_slot == SW'(CORE_MIN - 1);
  always_comb begin
    w_next = ST_CORE;
    case (r_state)
      ST_CORE: w_next = ext_req ? ST_EXT : ST_CORE;
      ST_EXT:  w_next = !ext_req ? ST_CORE : w_last_beat ? ST_SLOT : ST_EXT;
      ST_SLOT: w_next = w_last_slot ? ST_CORE : ST_SLOT;
      default: w_next = ST_CORE;
    endcase
  end
  // beats only advances on granted beats, slot only while in SLOT; both clear otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CORE;
      r_beats <= '0;
      r_slot <= '0;
    end else begin
      r_state <= w_next;
      r_beats <= w_beat ? r_beats + 1'b1 : '0;
      r_slot <= (r_state == ST_SLOT) ? r_slot + 1'b1 : '0;
    end
  end
  assign ext_gnt = w_ext;
  assign core_ce = !w_ext;
  // a core write held while frozen is masked here and lands once the core is re-enabled
  assign mem_addr = w_ext ? ext_addr : core_addr;
  assign mem_wdat = w_ext ? ext_wdat : core_wdat;
  assign mem_we = w_ext ? (ext_req & ext_we) : core_w;
  assign mem_re = w_ext ? (ext_req & ~ext_we) : core_r;
  assign core_rdat = mem_rdat;
  assign ext_rdat = mem_rdat;
  assign ext_rvalid = w_ext & ext_req & ~ext_we;
endmodule

// File: tb/tb_atwo_mbus_arbiter.sv
// tb_atwo_mbus_arbiter: directed and random checks of bus ownership against a behavioural model
module tb_atwo_mbus_arbiter;
  localparam int BM = 4;
  localparam int CM = 2;
  logic clk = 0;
  logic reset = 1;
  logic [7:0] core_addr = 0, core_wdat = 0, ext_addr = 0, ext_wdat = 0;
  logic core_r = 0, core_w = 0, ext_req = 0, ext_we = 0;
  logic [7:0] core_rdat, ext_rdat, mem_addr, mem_wdat, mem_rdat;
  logic core_ce, ext_gnt, ext_rvalid, mem_we, mem_re;
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  int wcount [256];
  logic gq [$];
  logic rq [$];
  int vectors = 0, errors = 0;
  logic m_gnt = 0;
  int m_beats = 0, m_slot = 0;
  int ext_left = 0;
  bit rnd = 0;
  always #5 clk = ~clk;
  assign mem_rdat = mem[mem_addr];
  atwo_mbus_arbiter #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(BM), .CORE_MIN(CM)) dut (
    .clk(clk), .reset(reset), .core_addr(core_addr), .core_wdat(core_wdat), .core_r(core_r),
    .core_w(core_w), .core_rdat(core_rdat), .core_ce(core_ce), .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdat(ext_wdat), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdat(ext_rdat), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdat(mem_rdat)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] pack(input logic q [$], input int n);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | 32'(q[i]);
    return v;
  endfunction
  task automatic tick();
    logic own, e_we, e_re, e_rv, a_we, beat;
    logic [7:0] e_addr, e_wdat, e_rd, a_addr, a_wdat;
    int op;
    @(negedge clk);
    own = m_gnt;
    e_addr = own ? ext_addr : core_addr;
    e_wdat = own ? ext_wdat : core_wdat;
    e_we = own ? (ext_req & ext_we) : core_w;
    e_re = own ? (ext_req & ~ext_we) : core_r;
    e_rv = own & ext_req & ~ext_we;
    e_rd = exp_mem[e_addr];
    check("ext_gnt", ext_gnt, own);
    check("core_ce", core_ce, !own);
    check("mem_we", mem_we, e_we);
    check("mem_re", mem_re, e_re);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdat", mem_wdat, e_wdat);
    check("ext_rvalid", ext_rvalid, e_rv);
    check("ext_rdat", ext_rdat, e_rd);
    check("core_rdat", core_rdat, e_rd);
    gq.push_back(ext_gnt);
    rq.push_back(ext_rvalid);
    a_we = mem_we;
    a_addr = mem_addr;
    a_wdat = mem_wdat;
    @(posedge clk);
    if (a_we) begin
      mem[a_addr] = a_wdat;
      wcount[a_addr]++;
    end
    if (e_we) exp_mem[e_addr] = e_wdat;
    // owner model: grant after a request, at most BM beats, then CM forced core cycles
    if (reset) begin
      m_gnt = 0; m_beats = 0; m_slot = 0;
    end else if (m_slot > 0) m_slot--;
    else if (!m_gnt) begin
      if (ext_req) begin m_gnt = 1; m_beats = 0; end
    end else if (!ext_req) m_gnt = 0;
    else begin
      m_beats++;
      if (m_beats == BM) begin m_gnt = 0; m_slot = CM; end
    end
    #1;
    beat = own & ext_req;
    if (beat) begin
      ext_left--;
      if (rnd) begin
        ext_we = 1'($urandom_range(0, 1)); ext_addr = 8'($urandom); ext_wdat = 8'($urandom);
      end else begin
        ext_addr++; ext_wdat++;
      end
    end
    if (rnd && ext_left == 0 && $urandom_range(0, 3) == 0) begin
      ext_left = $urandom_range(1, 7);
      ext_we = 1'($urandom_range(0, 1)); ext_addr = 8'($urandom); ext_wdat = 8'($urandom);
    end
    ext_req = ext_left > 0;
    if (!own) begin
      if (rnd) begin
        op = $urandom_range(0, 3);
        core_r = op == 1; core_w = op >= 2;
        core_addr = 8'($urandom); core_wdat = 8'($urandom);
      end else begin
        core_r = 0; core_w = 0;
      end
    end
    if (rnd) reset = $urandom_range(0, 99) == 0;
  endtask
  initial begin
    int w0, w1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 37 + 5); exp_mem[i] = 8'(i * 37 + 5); wcount[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    // reset held with a pending single external write
    ext_we = 1; ext_addr = 8'h40; ext_wdat = 8'hA5; ext_left = 1; ext_req = 1;
    gq.delete();
    tick(); tick();
    reset = 0;
    repeat (4) tick();
    check("t1_gnt_seq", pack(gq, 6), 32'b000110);
    check("t1_mem40", mem[8'h40], 8'hA5);
    // held read burst of 6 beats
    ext_we = 0; ext_addr = 8'h10; ext_left = 6; ext_req = 1;
    gq.delete(); rq.delete();
    repeat (12) tick();
    check("t2_gnt_seq", pack(gq, 12), 32'b011110001110);
    check("t2_rv_seq", pack(rq, 12), 32'b011110001100);
    // core write colliding with a rising external request
    w0 = wcount[8'h20]; w1 = wcount[8'h21];
    core_w = 1; core_addr = 8'h20; core_wdat = 8'h3C;
    ext_we = 1; ext_addr = 8'h21; ext_wdat = 8'h77; ext_left = 1; ext_req = 1;
    repeat (4) tick();
    check("t3_mem20", mem[8'h20], 8'h3C);
    check("t3_mem21", mem[8'h21], 8'h77);
    check("t3_cnt20", 32'(wcount[8'h20] - w0), 1);
    check("t3_cnt21", 32'(wcount[8'h21] - w1), 1);
    // core write asserted while frozen
    ext_we = 1; ext_addr = 8'h50; ext_wdat = 8'h11; ext_left = 3; ext_req = 1;
    tick();
    w0 = wcount[8'h30];
    core_w = 1; core_addr = 8'h30; core_wdat = 8'h5A;
    repeat (7) tick();
    check("t4_cnt30", 32'(wcount[8'h30] - w0), 1);
    check("t4_mem30", mem[8'h30], 8'h5A);
    // reset in the middle of a burst
    ext_we = 0; ext_addr = 8'h00; ext_left = 8; ext_req = 1;
    gq.delete();
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    repeat (6) tick();
    check("t5_gnt_seq", pack(gq, 10), 32'b0111011110);
    ext_left = 0; ext_req = 0;
    repeat (4) tick();
    // random traffic
    rnd = 1;
    repeat (3000) tick();
    rnd = 0; reset = 0; ext_left = 0; ext_req = 0; core_w = 0; core_r = 0;
    repeat (8) tick();
    for (int i = 0; i < 256; i++) check("final_mem", mem[i], exp_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
